// File: rtl/chrseq_pkg.sv
// Shared types and constants for the character-address sequencer.
// Holds the fa select encoding, the FSM states and the grant types.
package chrseq_pkg;

    localparam logic [1:0] FA_CLO = 2'b00;
    localparam logic [1:0] FA_CHI = 2'b01;
    localparam logic [1:0] FA_DIR = 2'b10;
    localparam logic [1:0] FA_S   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAT_LO,
        ST_LAT_HI,
        ST_PH0,
        ST_PH1
    } state_t;

    typedef enum logic [1:0] {
        G_SPR,
        G_FIX,
        G_DIR
    } gtype_t;

    // Grant vector bit order: [0]=spr, [1]=fix, [2]=dir.
    function automatic gtype_t gnt_to_type(logic [2:0] gnt);
        gtype_t t;
        t = G_SPR;
        if (gnt[1]) begin
            t = G_FIX;
        end else if (gnt[2]) begin
            t = G_DIR;
        end
        return t;
    endfunction

    // Select used for the first output phase of a grant.
    function automatic logic [1:0] fa_first(gtype_t g);
        logic [1:0] f;
        case (g)
            G_SPR:   f = FA_CLO;
            G_FIX:   f = FA_S;
            default: f = FA_DIR;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/chrseq_arb.sv
// Three-way round-robin arbiter (spr -> fix -> dir). The search starts at
// the requester after the last one granted; the pointer moves only on i_adv.
module chrseq_arb
    import chrseq_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_req,
    input  logic       i_adv,
    output logic [2:0] o_gnt
);

    logic [1:0] r_ptr;
    logic [1:0] w_ptr_nx;
    logic [2:0] w_gnt;

    always_comb begin
        w_gnt = 3'b000;
        case (r_ptr)
            2'd1: begin
                if (i_req[1])      w_gnt = 3'b010;
                else if (i_req[2]) w_gnt = 3'b100;
                else if (i_req[0]) w_gnt = 3'b001;
            end
            2'd2: begin
                if (i_req[2])      w_gnt = 3'b100;
                else if (i_req[0]) w_gnt = 3'b001;
                else if (i_req[1]) w_gnt = 3'b010;
            end
            default: begin
                if (i_req[0])      w_gnt = 3'b001;
                else if (i_req[1]) w_gnt = 3'b010;
                else if (i_req[2]) w_gnt = 3'b100;
            end
        endcase
    end

    always_comb begin
        w_ptr_nx = r_ptr;
        if (i_adv) begin
            case (w_gnt)
                3'b001:  w_ptr_nx = 2'd1;
                3'b010:  w_ptr_nx = 2'd2;
                3'b100:  w_ptr_nx = 2'd0;
                default: w_ptr_nx = r_ptr;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= 2'd0;
        end else begin
            r_ptr <= w_ptr_nx;
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/chrseq.sv
// Sequencer for the character-address multiplexer: arbitrates the P bus and
// latch strobes, walks fa through each grant's phases and flags stable f.
module chrseq
    import chrseq_pkg::*;
#(
    parameter int HOLD = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_spr_req,
    input  logic [23:0] i_spr_addr,
    output logic        o_spr_ack,
    input  logic        i_fix_req,
    input  logic [15:0] i_fix_addr,
    output logic        o_fix_ack,
    input  logic        i_dir_req,
    output logic        o_dir_ack,
    output logic [23:0] o_p,
    output logic        o_pck1b,
    output logic        o_pck2b,
    output logic [1:0]  o_fa,
    output logic        o_fvalid,
    output logic        o_busy
);

    localparam int            CW       = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);

    state_t        r_state;
    state_t        w_state_nx;
    gtype_t        r_gtype;
    gtype_t        w_gtype_nx;
    gtype_t        w_gnt_type;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;

    logic [2:0]    w_req;
    logic [2:0]    w_gnt;
    logic          w_last_phase;
    logic          w_decide;
    logic          w_take;
    logic [1:0]    w_fa_nx;
    logic          w_in_phase_nx;

    logic [23:0]   r_p;
    logic [1:0]    r_fa;
    logic          r_pck1b;
    logic          r_pck2b;
    logic          r_fvalid;
    logic          r_busy;
    logic          r_spr_ack;
    logic          r_fix_ack;
    logic          r_dir_ack;

    assign w_req = {i_dir_req, i_fix_req, i_spr_req};

    // A new grant can start in IDLE or on the final cycle of the last phase,
    // which lets back-to-back grants run without a gap cycle.
    assign w_last_phase = (r_cnt == CNT_LAST) &&
                          ((r_state == ST_PH1) ||
                           ((r_state == ST_PH0) && (r_gtype != G_SPR)));
    assign w_decide     = (r_state == ST_IDLE) || w_last_phase;
    assign w_take       = w_decide && (w_gnt != 3'b000);
    assign w_gnt_type   = gnt_to_type(w_gnt);

    chrseq_arb u_arb (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_req (w_req),
        .i_adv (w_take),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_state_nx = r_state;
        w_gtype_nx = r_gtype;
        w_cnt_nx   = r_cnt;
        if (w_take) begin
            w_gtype_nx = w_gnt_type;
            w_cnt_nx   = '0;
            w_state_nx = (w_gnt_type == G_DIR) ? ST_PH0 : ST_LAT_LO;
        end else if (w_decide) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                ST_LAT_LO: w_state_nx = ST_LAT_HI;
                ST_LAT_HI: begin
                    w_state_nx = ST_PH0;
                    w_cnt_nx   = '0;
                end
                ST_PH0: begin
                    if (r_cnt != CNT_LAST) begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end else begin
                        w_state_nx = ST_PH1;
                        w_cnt_nx   = '0;
                    end
                end
                ST_PH1:  w_cnt_nx = r_cnt + 1'b1;
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    // Outputs are computed from the next state so they stay fully registered;
    // fa keeps its last value outside the phase states to avoid glitches.
    always_comb begin
        w_fa_nx       = r_fa;
        w_in_phase_nx = 1'b0;
        if (w_state_nx == ST_PH0) begin
            w_fa_nx       = fa_first(w_gtype_nx);
            w_in_phase_nx = 1'b1;
        end else if (w_state_nx == ST_PH1) begin
            w_fa_nx       = FA_CHI;
            w_in_phase_nx = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_gtype   <= G_SPR;
            r_cnt     <= '0;
            r_p       <= 24'h000000;
            r_fa      <= FA_CLO;
            r_pck1b   <= 1'b1;
            r_pck2b   <= 1'b1;
            r_fvalid  <= 1'b0;
            r_busy    <= 1'b0;
            r_spr_ack <= 1'b0;
            r_fix_ack <= 1'b0;
            r_dir_ack <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_gtype   <= w_gtype_nx;
            r_cnt     <= w_cnt_nx;
            r_fa      <= w_fa_nx;
            r_fvalid  <= w_in_phase_nx && (w_cnt_nx == CNT_LAST);
            r_pck1b   <= !((w_state_nx == ST_LAT_LO) && (w_gtype_nx == G_SPR));
            r_pck2b   <= !((w_state_nx == ST_LAT_LO) && (w_gtype_nx == G_FIX));
            r_busy    <= (w_state_nx != ST_IDLE);
            r_spr_ack <= w_take && w_gnt[0];
            r_fix_ack <= w_take && w_gnt[1];
            r_dir_ack <= w_take && w_gnt[2];
            if (w_take && w_gnt[0]) begin
                r_p <= i_spr_addr;
            end else if (w_take && w_gnt[1]) begin
                r_p <= {8'h00, i_fix_addr};
            end
        end
    end

    assign o_p       = r_p;
    assign o_fa      = r_fa;
    assign o_pck1b   = r_pck1b;
    assign o_pck2b   = r_pck2b;
    assign o_fvalid  = r_fvalid;
    assign o_busy    = r_busy;
    assign o_spr_ack = r_spr_ack;
    assign o_fix_ack = r_fix_ack;
    assign o_dir_ack = r_dir_ack;

endmodule

// File: tb/tb_chrseq.sv
// Bench for chrseq: directed scenarios plus randomized requesters, checked
// against a per-grant timeline model that replays each grant's waveform.
module tb_chrseq;

    localparam int HOLD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  reqv;
    logic [23:0] spr_addr;
    logic [15:0] fix_addr;
    logic        o_spr_ack;
    logic        o_fix_ack;
    logic        o_dir_ack;
    logic [23:0] o_p;
    logic        o_pck1b;
    logic        o_pck2b;
    logic [1:0]  o_fa;
    logic        o_fvalid;
    logic        o_busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    chrseq #(.HOLD(HOLD)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_spr_req  (reqv[0]),
        .i_spr_addr (spr_addr),
        .o_spr_ack  (o_spr_ack),
        .i_fix_req  (reqv[1]),
        .i_fix_addr (fix_addr),
        .o_fix_ack  (o_fix_ack),
        .i_dir_req  (reqv[2]),
        .o_dir_ack  (o_dir_ack),
        .o_p        (o_p),
        .o_pck1b    (o_pck1b),
        .o_pck2b    (o_pck2b),
        .o_fa       (o_fa),
        .o_fvalid   (o_fvalid),
        .o_busy     (o_busy)
    );

    // Reference model: each grant is expanded into its cycle-by-cycle record
    // list {fa, pck1b, pck2b, fvalid, ack[2:0]}; the queue front is the
    // current cycle, an empty queue means idle.
    logic [7:0]  mq[$];
    logic [23:0] m_p;
    logic [1:0]  m_fa;
    int          m_ptr;

    task automatic push_phase(input logic [1:0] fa, input logic [2:0] ack0);
        for (int h = 0; h < HOLD; h++) begin
            mq.push_back({fa, 1'b1, 1'b1, (h == HOLD - 1), (h == 0) ? ack0 : 3'b000});
        end
    endtask

    always @(posedge clk or posedge rst) begin
        int g;
        if (rst) begin
            mq.delete();
            m_ptr = 0;
            m_p   = 24'h0;
            m_fa  = 2'b00;
        end else begin
            if (mq.size() > 0) void'(mq.pop_front());
            if (mq.size() == 0) begin
                g = -1;
                for (int i = 0; i < 3; i++) begin
                    if (g < 0 && reqv[(m_ptr + i) % 3]) g = (m_ptr + i) % 3;
                end
                if (g == 0) begin
                    m_p = spr_addr;
                    mq.push_back({m_fa, 1'b0, 1'b1, 1'b0, 3'b001});
                    mq.push_back({m_fa, 1'b1, 1'b1, 1'b0, 3'b000});
                    push_phase(2'b00, 3'b000);
                    push_phase(2'b01, 3'b000);
                    m_fa = 2'b01;
                end else if (g == 1) begin
                    m_p = {8'h00, fix_addr};
                    mq.push_back({m_fa, 1'b1, 1'b0, 1'b0, 3'b010});
                    mq.push_back({m_fa, 1'b1, 1'b1, 1'b0, 3'b000});
                    push_phase(2'b11, 3'b000);
                    m_fa = 2'b11;
                end else if (g == 2) begin
                    push_phase(2'b10, 3'b100);
                    m_fa = 2'b10;
                end
                if (g >= 0) m_ptr = (g + 1) % 3;
            end
        end
    end

    // Vector layout: {p[23:0], fa[1:0], pck1b, pck2b, fvalid, busy, ack[2:0]}
    function automatic logic [32:0] model_vec();
        logic [7:0] r;
        logic       bz;
        if (mq.size() > 0) begin
            r  = mq[0];
            bz = 1'b1;
        end else begin
            r  = {m_fa, 1'b1, 1'b1, 1'b0, 3'b000};
            bz = 1'b0;
        end
        return {m_p, r[7:6], r[5], r[4], r[3], bz, r[2:0]};
    endfunction

    function automatic logic [32:0] dut_vec();
        return {o_p, o_fa, o_pck1b, o_pck2b, o_fvalid, o_busy,
                o_dir_ack, o_fix_ack, o_spr_ack};
    endfunction

    function automatic logic [32:0] mk(input logic [23:0] p, input logic [1:0] fa,
                                       input logic p1, input logic p2, input logic fv,
                                       input logic bz, input logic [2:0] ack);
        return {p, fa, p1, p2, fv, bz, ack};
    endfunction

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        chk(tag, dut_vec(), model_vec());
    endtask

    logic [32:0] tab [8];

    task automatic run_tab(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step(tag);
            chk(tag, dut_vec(), tab[i]);
            if (i == 0) reqv = 3'b000;
        end
    endtask

    task automatic drain();
        reqv = 3'b000;
        for (int i = 0; i < 40 && o_busy; i++) step("drain");
        chk("drain_idle", {32'b0, o_busy}, 33'b0);
    endtask

    localparam logic [32:0] RSTV = {24'h0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000};

    initial begin
        logic [32:0] mv;
        logic [2:0]  ea;
        int          t;
        int          gi;
        int          glen [3];

        rst      = 1'b1;
        reqv     = 3'b000;
        spr_addr = 24'h0;
        fix_addr = 16'h0;
        repeat (2) @(negedge clk);
        chk("reset", dut_vec(), RSTV);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step("idle");
            chk("idle_const", dut_vec(), RSTV);
        end

        // single sprite fetch
        spr_addr = 24'hABCDEF;
        reqv     = 3'b001;
        tab[0] = mk(24'hABCDEF, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 3'b001);
        tab[1] = mk(24'hABCDEF, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000);
        tab[2] = mk(24'hABCDEF, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000);
        tab[3] = mk(24'hABCDEF, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000);
        tab[4] = mk(24'hABCDEF, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000);
        tab[5] = mk(24'hABCDEF, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000);
        tab[6] = mk(24'hABCDEF, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
        run_tab("spr", 7);

        // single fix fetch
        fix_addr = 16'h1234;
        reqv     = 3'b010;
        tab[0] = mk(24'h001234, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010);
        tab[1] = mk(24'h001234, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000);
        tab[2] = mk(24'h001234, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000);
        tab[3] = mk(24'h001234, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000);
        tab[4] = mk(24'h001234, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
        run_tab("fix", 5);

        // single direct phase
        spr_addr = 24'h777777;
        reqv     = 3'b100;
        tab[0] = mk(24'h001234, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 3'b100);
        tab[1] = mk(24'h001234, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000);
        tab[2] = mk(24'h001234, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
        run_tab("dir", 3);

        // all three held: round-robin, back-to-back, no idle cycles
        glen[0]  = 2 + 2 * HOLD;
        glen[1]  = 2 + HOLD;
        glen[2]  = HOLD;
        spr_addr = 24'h111111;
        fix_addr = 16'h2222;
        reqv     = 3'b111;
        t  = 0;
        gi = 0;
        for (int c = 0; c < 30; c++) begin
            step("held");
            ea = 3'b000;
            if (c == t) begin
                ea = 3'(1 << gi);
                t  = t + glen[gi];
                gi = (gi + 1) % 3;
            end
            chk("held_ack_busy", {29'b0, o_busy, o_dir_ack, o_fix_ack, o_spr_ack},
                {29'b0, 1'b1, ea});
        end
        drain();

        // reset in the middle of a sprite latch
        spr_addr = 24'h5A5A5A;
        reqv     = 3'b001;
        step("mid_ack");
        chk("mid_latch", {31'b0, o_pck1b, o_spr_ack}, {31'b0, 1'b0, 1'b1});
        rst  = 1'b1;
        reqv = 3'b011;
        #1;
        chk("rst_async", dut_vec(), RSTV);
        @(negedge clk);
        chk("rst_held", dut_vec(), RSTV);
        rst = 1'b0;
        step("rst_rel");
        chk("rst_ptr", {30'b0, o_dir_ack, o_fix_ack, o_spr_ack}, {30'b0, 3'b001});
        reqv[0] = 1'b0;

        // randomized requesters obeying the req/ack protocol
        for (int r = 0; r < 600; r++) begin
            step("rnd");
            mv = model_vec();
            for (int i = 0; i < 3; i++) begin
                if (reqv[i] && mv[i]) begin
                    reqv[i] = ($urandom_range(0, 1) == 1);
                    if (i == 0) spr_addr = 24'($urandom);
                    if (i == 1) fix_addr = 16'($urandom);
                end else if (reqv[i]) begin
                    if ($urandom_range(0, 15) == 0) reqv[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    reqv[i] = 1'b1;
                    if (i == 0) spr_addr = 24'($urandom);
                    if (i == 1) fix_addr = 16'($urandom);
                end
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/chrseq.md
# chrseq

Sequencer and arbiter for the character-address multiplexer. It shares the P bus and the two latch strobes `pck1b`/`pck2b` between three requesters:
- sprite C-ROM fetches: 24-bit address, two output phases
- fix S-ROM fetches: 16-bit address, one output phase
- direct sprite-data address: no latch, one phase

It drives the multiplexer select `fa` through the required phases and flags when the multiplexer output `f` is stable. It sits between the sprite/fix engines and the multiplexer, in the video clock domain.

## Interface
Parameters:
- `HOLD`, default 2: cycles each `fa` phase is held, ≥1.

Ports:
- `clk`  in  1  video clock. The block has one clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `spr_req`  in  1  sprite fetch request. Held until `spr_ack`.
- `spr_addr`  in  24  C-ROM address. Stable while `spr_req` is high.
- `spr_ack`  out  1  one-cycle pulse: address captured, requester may change it.
- `fix_req`  in  1  fix fetch request. Held until `fix_ack`.
- `fix_addr`  in  16  S-ROM address.
- `fix_ack`  out  1  one-cycle pulse.
- `dir_req`  in  1  direct-address phase request. Held until `dir_ack`.
- `dir_ack`  out  1  one-cycle pulse.
- `p`  out  24  P bus to the multiplexer latches.
- `pck1b`  out  1  C-address latch strobe. Idle high; the rising edge latches `p`.
- `pck2b`  out  1  S-address latch strobe. Idle high; the rising edge latches `p[15:0]`.
- `fa`  out  2  multiplexer select.
- `fvalid`  out  1  high in the last cycle of each `fa` phase; `f` is stable.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- `fa` encoding:
  - 00: C address low word
  - 01: C address high byte
  - 10: direct sprite-data address
  - 11: S address
- States: IDLE, LAT_LO, LAT_HI, PH0, PH1.
- Grant arbitration:
  - Grants are decided in IDLE and in the final cycle of a grant's last phase.
  - Round-robin in the order spr→fix→dir, starting from the requester after the last one granted.
  - The pointer resets to spr.
- On a grant the same edge does all of the following:
  - Pulses the matching `*_ack`.
  - Latches the grant type.
  - For spr: `p<=spr_addr`. For fix: `p<={8'h00,fix_addr}`. For dir: `p` is unchanged.
- spr grant: LAT_LO (`pck1b`=0) → LAT_HI (`pck1b`=1; rising edge, `p` still held) → PH0 with `fa`=00 for HOLD cycles → PH1 with `fa`=01 for HOLD cycles.
- fix grant: LAT_LO (`pck2b`=0) → LAT_HI → PH0 with `fa`=11 for HOLD cycles.
- dir grant: PH0 with `fa`=10 for HOLD cycles. No strobe.
- After the last phase, the next state is one of:
  - the next grant's first state, with no gap cycle, if any request is pending;
  - IDLE otherwise.
- `fa` holds its previous value in IDLE, LAT_LO and LAT_HI, so it never glitches.
- `p` holds its last value until the next spr or fix grant.
- Exactly one of `pck1b`/`pck2b` is low in any cycle, or neither.
- A phase counter counts 0..HOLD-1. `fvalid` is asserted at count HOLD-1.

## Timing
- All outputs are registered.
- Reset values:
  - `p`=0, `fa`=00
  - `pck1b`=1, `pck2b`=1
  - `spr_ack`=`fix_ack`=`dir_ack`=0
  - `fvalid`=0, `busy`=0
  - state IDLE, pointer spr.
- Request sampled at edge k → ack high in cycle k (after edge k).
- Grant lengths:
  - spr: 2+2·HOLD cycles
  - fix: 2+HOLD cycles
  - dir: HOLD cycles
- Request/ack rules:
  - A request that is still high in the ack cycle is a new request. The requester must drop it, or present the next address, in the ack cycle.
  - A request withdrawn before its ack is legal and is simply not granted.
- Simultaneous requests are resolved by the round-robin pointer only. There is no fixed priority.
- Reset mid-operation:
  - Outputs go to reset values immediately and asynchronously.
  - A strobe that was low returns high, which can latch a partial address. This is acceptable: the aborted fetch is discarded.
  - No ack is reissued for an already-acked grant.

## Structure
- Package `chrseq_pkg` holds:
  - `fa` encoding constants `FA_CLO`, `FA_CHI`, `FA_DIR`, `FA_S`
  - state enum
  - grant-type enum (`G_SPR`, `G_FIX`, `G_DIR`)
- Sub-module `chrseq_arb`: 3-way round-robin arbiter.
  - Inputs: requests, advance strobe.
  - Output: one-hot grant.
  - Owns the pointer register.
- The top level holds the FSM, phase counter and output registers.

## Test plan
All scenarios use HOLD=2.
- Reset, then idle:
  - All outputs hold their reset values for 10 cycles.
  - `pck1b`=`pck2b`=1, `busy`=0.
- Single `spr_req` with `spr_addr`=24'hABCDEF, sampled at edge k:
  - `spr_ack` and `pck1b`=0 at k; `pck1b`=1 at k+1.
  - `fa`=00 at k+2..k+3, `fvalid` at k+3.
  - `fa`=01 at k+4..k+5, `fvalid` at k+5.
  - IDLE at k+6.
  - `p`=24'hABCDEF throughout.
- Single `fix_req` with `fix_addr`=16'h1234:
  - `p`=24'h001234, `pck2b` low for one cycle.
  - `fa`=11 for 2 cycles; 4 cycles total.
  - `pck1b` stays 1.
- Single `dir_req`:
  - `fa`=10 for 2 cycles, `fvalid` on the second.
  - No strobe activity; `p` unchanged.
- All three requests held continuously:
  - Grant order spr, fix, dir, spr, … back-to-back.
  - Each ack is exactly one cycle, with no IDLE cycles between grants.
- Reset asserted during `spr` LAT_LO:
  - `pck1b`=1 and `fa`=00 immediately, `busy`=0.
  - After release with `fix_req` and `spr_req` both high, spr is granted first (pointer reset).
